mul_issue_ctrl: RTL and testbench

- Sequencing controller between the EX stage and the iterative shift-add multiplier engine of the RV64 core.
- Accepts one multiply request at a time over a valid/ready handshake and converts operands to magnitudes per RV64M op.
- Launches the engine, waits for completion, and applies sign correction and result selection.
- Returns the result over a valid/ready response channel. Supports pipeline flush, a zero-operand fast path and a watchdog.

---
 rtl/mul_issue_ctrl_if.sv | 28 ++
 rtl/mul_issue_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_mul_issue_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_issue_ctrl_if.sv
// Request/response channel between the EX stage and the multiply issue controller.
// The EX stage is the master; mul_issue_ctrl is the slave.
interface mul_issue_ctrl_if #(
    parameter int TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [63:0]      req_op1;
    logic [63:0]      req_op2;
    logic [TAG_W-1:0] req_tag;

    logic             resp_valid;
    logic             resp_ready;
    logic [63:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_err;

    modport master (
        output req_valid, req_op, req_op1, req_op2, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_tag, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_op1, req_op2, req_tag, resp_ready,
        output req_ready, resp_valid, resp_data, resp_tag, resp_err
    );
endinterface

// File: rtl/mul_issue_ctrl.sv
// Sequencer between EX and the iterative shift-add multiplier: operand magnitudes, launch,
// sign fix-up, flush/watchdog abort. Optional 1-entry result cache under `MUL_REUSE_EN.
module mul_issue_ctrl #(
    parameter int TAG_W    = 5,
    parameter int WDOG_MAX = 96
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    mul_issue_ctrl_if.slave bus,
    output logic           busy,
    output logic           eng_start,
    output logic           eng_kill,
    output logic [63:0]    eng_a,
    output logic [63:0]    eng_b,
    input  logic           eng_done,
    input  logic [127:0]   eng_prod
);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_MULW   = 3'b100;

    localparam int WDOG_W = $clog2(WDOG_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY,
        DONE
    } state_t;

    state_t             state;
    state_t             next_state;

    logic               accept;
    logic               timeout;
    logic [WDOG_W-1:0]  wdog;
    logic               wdog_hit;

    logic               neg_q;
    logic [2:0]         op_q;
    logic [TAG_W-1:0]   tag_q;
    logic [63:0]        data_q;
    logic               err_q;

    logic [63:0]        ext1;
    logic [63:0]        ext2;
    logic [63:0]        mag1;
    logic [63:0]        mag2;
    logic               sa;
    logic               sb;
    logic               neg1;
    logic               neg2;
    logic               fast;

    logic [127:0]       p;
    logic [63:0]        result;

    logic               hit;
    logic [63:0]        hit_data;

    assign bus.req_ready  = (state == IDLE) & ~flush;
    assign accept         = bus.req_valid & bus.req_ready;
    assign busy           = (state != IDLE);
    assign bus.resp_valid = (state == DONE);
    assign bus.resp_data  = data_q;
    assign bus.resp_tag   = tag_q;
    assign bus.resp_err   = err_q;
    assign wdog_hit       = (wdog == WDOG_W'(WDOG_MAX - 1));

    // Operand prep: MULW widens from bit 31 first, so the zero fast path sees the extended values.
    always_comb begin
        ext1 = bus.req_op1;
        ext2 = bus.req_op2;
        if (bus.req_op == OP_MULW) begin
            ext1 = {{32{bus.req_op1[31]}}, bus.req_op1[31:0]};
            ext2 = {{32{bus.req_op2[31]}}, bus.req_op2[31:0]};
        end
        sa   = (bus.req_op == OP_MUL) || (bus.req_op == OP_MULH) ||
               (bus.req_op == OP_MULHSU) || (bus.req_op == OP_MULW);
        sb   = (bus.req_op == OP_MUL) || (bus.req_op == OP_MULH) ||
               (bus.req_op == OP_MULW);
        neg1 = sa & ext1[63];
        neg2 = sb & ext2[63];
        mag1 = neg1 ? (~ext1 + 64'd1) : ext1;
        mag2 = neg2 ? (~ext2 + 64'd1) : ext2;
        fast = (bus.req_op > OP_MULW) || (ext1 == 64'd0) || (ext2 == 64'd0);
    end

    always_comb begin
        p = neg_q ? (~eng_prod + 128'd1) : eng_prod;
        case (op_q)
            OP_MUL:  result = p[63:0];
            OP_MULW: result = {{32{p[31]}}, p[31:0]};
            default: result = p[127:64];
        endcase
    end

`ifdef MUL_REUSE_EN
    logic        c_valid;
    logic [2:0]  c_op;
    logic [63:0] c_op1;
    logic [63:0] c_op2;
    logic [63:0] c_res;
    logic [63:0] raw1_q;
    logic [63:0] raw2_q;

    // Only engine-completed ops ever land here, so a hit can never collide with the fast path.
    assign hit      = c_valid && (c_op == bus.req_op) &&
                      (c_op1 == bus.req_op1) && (c_op2 == bus.req_op2);
    assign hit_data = c_res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_valid <= 1'b0;
            c_op    <= 3'd0;
            c_op1   <= 64'd0;
            c_op2   <= 64'd0;
            c_res   <= 64'd0;
            raw1_q  <= 64'd0;
            raw2_q  <= 64'd0;
        end else begin
            if (accept) begin
                raw1_q <= bus.req_op1;
                raw2_q <= bus.req_op2;
            end
            if ((state == BUSY) && !flush && eng_done) begin
                c_valid <= 1'b1;
                c_op    <= op_q;
                c_op1   <= raw1_q;
                c_op2   <= raw2_q;
                c_res   <= result;
            end else if (timeout) begin
                c_valid <= 1'b0;
            end
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = 64'd0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Flush outranks eng_done; eng_done outranks the watchdog in the same BUSY cycle.
    always_comb begin
        next_state = state;
        eng_start  = 1'b0;
        eng_kill   = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (fast || hit) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                eng_start = 1'b1;
                if (flush) begin
                    eng_kill   = 1'b1;
                    next_state = IDLE;
                end else begin
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (flush) begin
                    eng_kill   = 1'b1;
                    next_state = IDLE;
                end else if (eng_done) begin
                    next_state = DONE;
                end else if (wdog_hit) begin
                    eng_kill   = 1'b1;
                    timeout    = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                if (flush || bus.resp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_a  <= 64'd0;
            eng_b  <= 64'd0;
            neg_q  <= 1'b0;
            op_q   <= 3'd0;
            tag_q  <= '0;
            data_q <= 64'd0;
            err_q  <= 1'b0;
            wdog   <= '0;
        end else begin
            if (accept) begin
                eng_a <= mag1;
                eng_b <= mag2;
                neg_q <= neg1 ^ neg2;
                op_q  <= bus.req_op;
                tag_q <= bus.req_tag;
                err_q <= 1'b0;
                if (fast) begin
                    data_q <= 64'd0;
                end else if (hit) begin
                    data_q <= hit_data;
                end
            end
            if (state == ISSUE) begin
                wdog <= '0;
            end else if ((state == BUSY) && !flush) begin
                wdog <= wdog + WDOG_W'(1);
                if (eng_done) begin
                    data_q <= result;
                end else if (wdog_hit) begin
                    data_q <= 64'd0;
                    err_q  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl: plays EX stage and multiplier engine, predicts every
// cycle's outputs from a timeline/arithmetic model of RV64M multiply semantics.
module tb_mul_issue_ctrl;

    localparam int TAG_W    = 5;
    localparam int WDOG_MAX = 96;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic           busy;
    logic           eng_start;
    logic           eng_kill;
    logic [63:0]    eng_a;
    logic [63:0]    eng_b;
    logic           eng_done;
    logic [127:0]   eng_prod;

    mul_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

    mul_issue_ctrl #(.TAG_W(TAG_W), .WDOG_MAX(WDOG_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus),
        .busy      (busy),
        .eng_start (eng_start),
        .eng_kill  (eng_kill),
        .eng_a     (eng_a),
        .eng_b     (eng_b),
        .eng_done  (eng_done),
        .eng_prod  (eng_prod)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic             mon_en = 1'b0;
    logic             exp_busy, exp_start, exp_kill, exp_rv, exp_err, exp_eng;
    logic [63:0]      exp_data, exp_a, exp_b;
    logic [TAG_W-1:0] exp_tag;
    logic [63:0]      last_data;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [63:0] sext32(input logic [63:0] x);
        return {{32{x[31]}}, x[31:0]};
    endfunction

    function automatic logic signedA(input logic [2:0] op);
        return (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4);
    endfunction

    function automatic logic signedB(input logic [2:0] op);
        return (op == 3'd0) || (op == 3'd1) || (op == 3'd4);
    endfunction

    function automatic logic [63:0] magOf(input logic [63:0] x, input logic s);
        return (s && x[63]) ? (64'd0 - x) : x;
    endfunction

    // Architectural result: full 128-bit product of the sign/zero-extended operands.
    function automatic logic [63:0] modelResult(input logic [2:0] op, input logic [63:0] a,
                                                input logic [63:0] b);
        logic [63:0]  ea, eb;
        logic [127:0] xa, xb, pr;
        if (op > 3'd4) return 64'd0;
        ea = (op == 3'd4) ? sext32(a) : a;
        eb = (op == 3'd4) ? sext32(b) : b;
        xa = signedA(op) ? {{64{ea[63]}}, ea} : {64'd0, ea};
        xb = signedB(op) ? {{64{eb[63]}}, eb} : {64'd0, eb};
        pr = xa * xb;
        case (op)
            3'd0:    return pr[63:0];
            3'd4:    return sext32(pr[63:0]);
            default: return pr[127:64];
        endcase
    endfunction

    // Compare process: every cycle, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            checkOutput("busy", 64'(busy), 64'(exp_busy));
            checkOutput("eng_start", 64'(eng_start), 64'(exp_start));
            checkOutput("eng_kill", 64'(eng_kill), 64'(exp_kill));
            checkOutput("resp_valid", 64'(bus.resp_valid), 64'(exp_rv));
            checkOutput("req_ready", 64'(bus.req_ready), 64'(!exp_busy && !flush));
            if (exp_rv) begin
                checkOutput("resp_data", bus.resp_data, exp_data);
                checkOutput("resp_tag", 64'(bus.resp_tag), 64'(exp_tag));
                checkOutput("resp_err", 64'(bus.resp_err), 64'(exp_err));
            end
            if (exp_eng) begin
                checkOutput("eng_a", eng_a, exp_a);
                checkOutput("eng_b", eng_b, exp_b);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setExp(input logic b, input logic s, input logic k, input logic rv,
                          input logic e);
        exp_busy  = b;
        exp_start = s;
        exp_kill  = k;
        exp_rv    = rv;
        exp_eng   = e;
    endtask

    // One request from accept to retirement. doneDly: BUSY cycle of eng_done (<0 never);
    // flushAt: BUSY cycle of flush (0 none); readyDly: cycles resp_ready stays low; drop: flush in DONE.
    task automatic applyStimulus(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                 input logic [TAG_W-1:0] tag, input int doneDly, input int flushAt,
                                 input int readyDly, input bit drop);
        logic [63:0] ea, eb;
        bit fast, fin, flushed;
        ea = (op == 3'd4) ? sext32(a) : a;
        eb = (op == 3'd4) ? sext32(b) : b;
        fast = (op > 3'd4) || (ea == 64'd0) || (eb == 64'd0);

        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_op1   = a;
        bus.req_op2   = b;
        bus.req_tag   = tag;
        setExp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        bus.req_valid = 1'b0;
        bus.req_op1   = {$urandom, $urandom};
        bus.req_op2   = {$urandom, $urandom};
        exp_tag  = tag;
        exp_err  = 1'b0;
        exp_data = modelResult(op, a, b);
        exp_a    = magOf(ea, signedA(op));
        exp_b    = magOf(eb, signedB(op));

        if (!fast) begin
            setExp(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
            step();
            fin = 1'b0;
            flushed = 1'b0;
            for (int k = 1; k <= WDOG_MAX && !fin; k++) begin
                setExp(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
                if (k == doneDly) begin
                    eng_done = 1'b1;
                    eng_prod = {64'd0, exp_a} * {64'd0, exp_b};
                end
                if (k == flushAt) begin
                    flush    = 1'b1;
                    exp_kill = 1'b1;
                    flushed  = 1'b1;
                end else if (doneDly < 0 && k == WDOG_MAX) begin
                    exp_kill = 1'b1;
                end
                fin = (k == doneDly) || (k == flushAt);
                step();
                eng_done = 1'b0;
                flush    = 1'b0;
            end
            if (flushed) begin
                setExp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                eng_done = 1'b1;
                eng_prod = {$urandom, $urandom, $urandom, $urandom};
                step();
                eng_done = 1'b0;
                return;
            end
            if (!fin) begin
                exp_err  = 1'b1;
                exp_data = 64'd0;
            end
        end

        setExp(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        if (drop) begin
            flush = 1'b1;
            step();
            flush = 1'b0;
            setExp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            return;
        end
        for (int r = 0; r <= readyDly; r++) begin
            bus.resp_ready = (r == readyDly);
            if (r == readyDly) last_data = bus.resp_data;
            step();
        end
        bus.resp_ready = 1'b0;
        setExp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [63:0] rndOperand();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'($urandom_range(1, 20));
            2:       return 64'd0 - 64'($urandom_range(1, 20));
            3:       return {32'd0, $urandom};
            4:       return {$urandom, 32'd0};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic [2:0] rop;
        rst = 1'b1;
        flush = 1'b0;
        eng_done = 1'b0;
        eng_prod = '0;
        bus.req_valid = 1'b0;
        bus.req_op = 3'd0;
        bus.req_op1 = 64'd0;
        bus.req_op2 = 64'd0;
        bus.req_tag = '0;
        bus.resp_ready = 1'b0;
        setExp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_err = 1'b0;
        exp_data = 64'd0;
        exp_a = 64'd0;
        exp_b = 64'd0;
        exp_tag = '0;
        last_data = 64'd0;

        #2;
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        checkOutput("rst_resp_data", bus.resp_data, 64'd0);
        checkOutput("rst_resp_tag", 64'(bus.resp_tag), 64'd0);
        checkOutput("rst_eng_a", eng_a, 64'd0);
        checkOutput("rst_eng_start", 64'(eng_start), 64'd0);
        step();
        rst = 1'b0;
        mon_en = 1'b1;
        step();

        applyStimulus(3'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 5'd7, 3, 0, 0, 1'b0);
        checkOutput("lit_mul_data", last_data, 64'hFFFF_FFFF_FFFF_FFF1);
        checkOutput("lit_mul_b_mag", exp_b, 64'd5);
        applyStimulus(3'd3, '1, '1, 5'd1, 2, 0, 1, 1'b0);
        checkOutput("lit_mulhu", last_data, 64'hFFFF_FFFF_FFFF_FFFE);
        applyStimulus(3'd1, '1, '1, 5'd2, 1, 0, 0, 1'b0);
        checkOutput("lit_mulh", last_data, 64'd0);
        applyStimulus(3'd4, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd3, 4, 0, 0, 1'b0);
        checkOutput("lit_mulw", last_data, 64'hFFFF_FFFF_FFFF_FFFE);
        applyStimulus(3'd2, '1, 64'd2, 5'd4, 2, 0, 0, 1'b0);
        checkOutput("lit_mulhsu", last_data, 64'hFFFF_FFFF_FFFF_FFFF);
        applyStimulus(3'd0, 64'd9, 64'd0, 5'd5, 3, 0, 0, 1'b0);
        checkOutput("lit_zero_fast", last_data, 64'd0);
        applyStimulus(3'd7, 64'd9, 64'd6, 5'd6, 3, 0, 0, 1'b0);
        checkOutput("lit_illegal_fast", last_data, 64'd0);

        applyStimulus(3'd0, 64'd11, 64'd13, 5'd8, 10, 3, 0, 1'b0);
        applyStimulus(3'd1, 64'd11, 64'd13, 5'd9, 4, 4, 0, 1'b0);
        applyStimulus(3'd0, 64'd21, 64'd2, 5'd10, 2, 0, 0, 1'b1);

        flush = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_op = 3'd0;
        bus.req_op1 = 64'd5;
        bus.req_op2 = 64'd6;
        setExp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        flush = 1'b0;
        bus.req_valid = 1'b0;
        step();

        applyStimulus(3'd0, 64'd123, 64'd456, 5'd11, -1, 0, 5, 1'b0);
        checkOutput("lit_wdog_data", last_data, 64'd0);

        mon_en = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_op = 3'd0;
        bus.req_op1 = 64'd3;
        bus.req_op2 = 64'd4;
        step();
        bus.req_valid = 1'b0;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_start", 64'(eng_start), 64'd0);
        checkOutput("midrst_kill", 64'(eng_kill), 64'd0);
        step();
        rst = 1'b0;
        setExp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b1;
        step();

        for (int i = 0; i < 60; i++) begin
            rop = ($urandom_range(0, 7) < 6) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 7));
            applyStimulus(rop, rndOperand(), rndOperand(), TAG_W'($urandom_range(0, 31)),
                          $urandom_range(1, 6),
                          ($urandom_range(0, 5) == 0) ? $urandom_range(1, 6) : 0,
                          $urandom_range(0, 3), ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 1) == 1) step();
        end

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
